// File: rtl/sh4_exu_issue.sv
// Issue/commit controller for the sh4_exu datapath: 2-entry instruction queue with
// register-file write bypass, write-port arbitration (EXU vs load writeback), and M/Q/S/T flags.
module sh4_exu_issue #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        iss_valid,
  output logic        iss_ready,
  input  logic [15:0] iss_raw,
  input  logic [31:0] iss_opl,
  input  logic [31:0] iss_oph,
  input  logic [4:0]  iss_srcl,
  input  logic [4:0]  iss_srch,
  output logic        exu_valid,
  output logic [15:0] exu_raw,
  output logic [31:0] exu_opl,
  output logic [31:0] exu_oph,
  output logic [3:0]  exu_flags,
  input  logic [3:0]  exu_out_flags,
  input  logic        exu_wen,
  input  logic [3:0]  exu_wdst,
  input  logic [31:0] exu_wdata,
  input  logic        lsu_valid,
  output logic        lsu_ready,
  input  logic [3:0]  lsu_dst,
  input  logic [31:0] lsu_data,
  output logic        rf_wen,
  output logic [3:0]  rf_wdst,
  output logic [31:0] rf_wdata,
  input  logic        sr_wen,
  input  logic [3:0]  sr_wdata,
  output logic [3:0]  sr_flags
);

  // Handshakes: a transfer happens on the rising edge where valid && ready are both high.
  // iss_ready comes from the registered count only; lsu_ready is the same-cycle write grant.
  localparam logic [1:0] FULL = 2'(DEPTH);

  logic [1:0]  count_q, count_d;
  logic        pri_q, pri_d;
  logic [3:0]  flags_q, flags_d;
  logic        blk_q, blk_d;
  logic [15:0] raw_q  [2];
  logic [15:0] raw_d  [2];
  logic [31:0] opl_q  [2];
  logic [31:0] opl_d  [2];
  logic [31:0] oph_q  [2];
  logic [31:0] oph_d  [2];
  logic [4:0]  srcl_q [2];
  logic [4:0]  srcl_d [2];
  logic [4:0]  srch_q [2];
  logic [4:0]  srch_d [2];
  logic [31:0] byp_opl [2];
  logic [31:0] byp_oph [2];

  logic        exu_req;
  logic        grant_ok;
  logic        lsu_gnt;
  logic        exu_gnt;
  logic        commit;
  logic        enq;
  logic        pos;
  logic [31:0] in_opl;
  logic [31:0] in_oph;

  function automatic logic [31:0] fwd(input logic [4:0] src, input logic [31:0] val,
                                      input logic wen, input logic [3:0] dst,
                                      input logic [31:0] data);
    return (wen && src[4] && (src[3:0] == dst)) ? data : val;
  endfunction

  assign iss_ready = (count_q != FULL);
  assign exu_valid = (count_q != 2'd0);
  assign exu_raw   = raw_q[0];
  assign exu_opl   = opl_q[0];
  assign exu_oph   = oph_q[0];
  assign exu_flags = flags_q;
  assign sr_flags  = flags_q;

  // Grants are suppressed during reset and the cycle after, so no stale write escapes a flush.
  always_comb begin
    exu_req  = exu_valid && exu_wen;
    grant_ok = !rst && !blk_q;
    lsu_gnt  = grant_ok && lsu_valid && (!exu_req || pri_q);
    exu_gnt  = grant_ok && exu_req && !lsu_gnt;
    commit   = exu_valid && (!exu_wen || exu_gnt);
    lsu_ready = lsu_gnt;
    rf_wen    = lsu_gnt || exu_gnt;
    rf_wdst   = lsu_gnt ? lsu_dst  : exu_wdst;
    rf_wdata  = lsu_gnt ? lsu_data : exu_wdata;
    pri_d     = (grant_ok && exu_req && lsu_valid) ? !pri_q : pri_q;
    blk_d     = rst;
    flags_d   = flags_q;
    if (commit) flags_d = exu_out_flags;
    if (sr_wen) flags_d = sr_wdata;
  end

  always_comb begin
    enq    = iss_valid && iss_ready;
    pos    = (count_q == 2'd1) && !commit;
    in_opl = fwd(iss_srcl, iss_opl, rf_wen, rf_wdst, rf_wdata);
    in_oph = fwd(iss_srch, iss_oph, rf_wen, rf_wdst, rf_wdata);
    for (int i = 0; i < 2; i++) begin
      byp_opl[i] = fwd(srcl_q[i], opl_q[i], rf_wen, rf_wdst, rf_wdata);
      byp_oph[i] = fwd(srch_q[i], oph_q[i], rf_wen, rf_wdst, rf_wdata);
      raw_d[i]   = raw_q[i];
      opl_d[i]   = byp_opl[i];
      oph_d[i]   = byp_oph[i];
      srcl_d[i]  = srcl_q[i];
      srch_d[i]  = srch_q[i];
    end
    // The departing head is not bypassed; the second entry shifts forward with its bypass.
    if (commit) begin
      raw_d[0]  = raw_q[1];
      opl_d[0]  = byp_opl[1];
      oph_d[0]  = byp_oph[1];
      srcl_d[0] = srcl_q[1];
      srch_d[0] = srch_q[1];
    end
    if (enq) begin
      raw_d[pos]  = iss_raw;
      opl_d[pos]  = in_opl;
      oph_d[pos]  = in_oph;
      srcl_d[pos] = iss_srcl;
      srch_d[pos] = iss_srch;
    end
    case ({enq, commit})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= 2'd0;
      pri_q   <= 1'b0;
      flags_q <= 4'b0000;
    end else begin
      count_q <= count_d;
      pri_q   <= pri_d;
      flags_q <= flags_d;
    end
    blk_q <= blk_d;
    for (int i = 0; i < 2; i++) begin
      raw_q[i]  <= raw_d[i];
      opl_q[i]  <= opl_d[i];
      oph_q[i]  <= oph_d[i];
      srcl_q[i] <= srcl_d[i];
      srch_q[i] <= srch_d[i];
    end
  end

endmodule
